// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch, decode and datapath control of the simple RISC machine
module cpu_controller (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] ir,
    output logic [1:0]  vsel,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_ir,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halted
);
    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    typedef enum logic [4:0] {
        S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B,
        S_ALU, S_ALU_S, S_WRITE_RD, S_ADDR, S_LD_ADDR, S_MEM_RD1, S_MEM_RD2,
        S_GET_RD, S_PASS, S_MEM_WR, S_HALT
    } state_t;

    state_t state, next;

    logic [4:0] instr;
    logic       is_ldr, is_str, is_cmp, is_mov;

    assign instr  = ir[15:11];
    assign is_ldr = instr == 5'b01100;
    assign is_str = instr == 5'b10000;
    assign is_cmp = instr == 5'b10101;
    assign is_mov = instr == 5'b11000;

    // State register; reset aborts any instruction in flight immediately
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= S_RST;
        else          state <= next;

    // Next-state: fixed fetch prologue, then dispatch on {opcode, op}
    always_comb begin
        next = S_RST;
        case (state)
            S_RST:       next = S_IF1;
            S_IF1:       next = S_IF2;
            S_IF2:       next = S_UPDATE_PC;
            S_UPDATE_PC: next = S_DECODE;
            S_DECODE:
                case (instr)
                    5'b11010:                    next = S_WRITE_IMM;
                    5'b11000, 5'b10111:          next = S_GET_B;
                    5'b10100, 5'b10110, 5'b10101,
                    5'b01100, 5'b10000:          next = S_GET_A;
                    default:                     next = S_HALT;
                endcase
            S_GET_A:     next = (is_ldr || is_str) ? S_ADDR : S_GET_B;
            S_GET_B:     next = is_cmp ? S_ALU_S : S_ALU;
            S_ALU:       next = S_WRITE_RD;
            S_ADDR:      next = S_LD_ADDR;
            S_LD_ADDR:   next = is_ldr ? S_MEM_RD1 : S_GET_RD;
            S_MEM_RD1:   next = S_MEM_RD2;
            S_GET_RD:    next = S_PASS;
            S_PASS:      next = S_MEM_WR;
            S_HALT:      next = S_HALT;
            S_WRITE_IMM, S_ALU_S, S_WRITE_RD, S_MEM_RD2, S_MEM_WR: next = S_IF1;
            default:     next = S_RST;
        endcase
    end

    // Control outputs depend on state only (ir fields are stable from DECODE on)
    always_comb begin
        vsel = 2'b00; writenum = 3'd0; readnum = 3'd0;
        write = 1'b0; loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
        asel = 1'b0; bsel = 1'b0; shift = 2'b00; ALUop = 2'b00;
        load_pc = 1'b0; reset_pc = 1'b0; load_ir = 1'b0; load_addr = 1'b0;
        addr_sel = 1'b0; mem_cmd = MNONE; halted = 1'b0;
        case (state)
            S_RST:       begin reset_pc = 1'b1; load_pc = 1'b1; end
            S_IF1:       begin addr_sel = 1'b1; mem_cmd = MREAD; end
            S_IF2:       begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; end
            S_UPDATE_PC: load_pc = 1'b1;
            S_WRITE_IMM: begin vsel = 2'b10; writenum = ir[10:8]; write = 1'b1; end
            S_GET_A:     begin readnum = ir[10:8]; loada = 1'b1; end
            S_GET_B:     begin readnum = ir[2:0]; loadb = 1'b1; end
            S_ALU:       begin shift = ir[4:3]; ALUop = ir[12:11]; asel = is_mov; loadc = 1'b1; end
            S_ALU_S:     begin shift = ir[4:3]; ALUop = ir[12:11]; asel = is_mov; loads = 1'b1; end
            S_WRITE_RD:  begin writenum = ir[7:5]; write = 1'b1; end
            S_ADDR:      begin bsel = 1'b1; loadc = 1'b1; end
            S_LD_ADDR:   load_addr = 1'b1;
            S_MEM_RD1:   mem_cmd = MREAD;
            S_MEM_RD2:   begin mem_cmd = MREAD; vsel = 2'b11; writenum = ir[7:5]; write = 1'b1; end
            S_GET_RD:    begin readnum = ir[7:5]; loadb = 1'b1; end
            S_PASS:      begin asel = 1'b1; loadc = 1'b1; end
            S_MEM_WR:    mem_cmd = MWRITE;
            S_HALT:      halted = 1'b1;
            default:     ;
        endcase
    end
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: per-cycle control-word check of cpu_controller against an instruction-level model
module tb_cpu_controller;
    typedef struct packed {
        logic [1:0] vsel;
        logic [2:0] writenum;
        logic [2:0] readnum;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] shift;
        logic [1:0] alu_op;
        logic       load_pc, reset_pc, load_ir, load_addr, addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctl_t;

    logic        clk, reset_n;
    logic [15:0] ir;
    logic [1:0]  vsel, shift, ALUop, mem_cmd;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic        load_pc, reset_pc, load_ir, load_addr, addr_sel, halted;
    ctl_t        act, rst_v, if1_v;
    ctl_t        exp_q[$];
    int          tests, fails;

    cpu_controller dut (
        .clk(clk), .reset_n(reset_n), .ir(ir),
        .vsel(vsel), .writenum(writenum), .readnum(readnum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop),
        .load_pc(load_pc), .reset_pc(reset_pc), .load_ir(load_ir),
        .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halted(halted)
    );

    assign act = {vsel, writenum, readnum, write, loada, loadb, loadc, loads, asel, bsel,
                  shift, ALUop, load_pc, reset_pc, load_ir, load_addr, addr_sel, mem_cmd, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for every cycle of one instruction, from IF1 onward
    function automatic void build(input logic [15:0] i);
        ctl_t c;
        logic [4:0] k;
        k = i[15:11];
        exp_q.delete();
        c = '0; c.addr_sel = 1; c.mem_cmd = 2'b01; exp_q.push_back(c);
        c.load_ir = 1; exp_q.push_back(c);
        c = '0; c.load_pc = 1; exp_q.push_back(c);
        c = '0; exp_q.push_back(c);
        if (k == 5'b11010) begin
            c = '0; c.vsel = 2'b10; c.writenum = i[10:8]; c.write = 1; exp_q.push_back(c);
        end else if (k inside {5'b11000, 5'b10111, 5'b10100, 5'b10110, 5'b10101}) begin
            if (!(k inside {5'b11000, 5'b10111})) begin
                c = '0; c.readnum = i[10:8]; c.loada = 1; exp_q.push_back(c);
            end
            c = '0; c.readnum = i[2:0]; c.loadb = 1; exp_q.push_back(c);
            c = '0; c.shift = i[4:3]; c.alu_op = i[12:11]; c.asel = (k == 5'b11000);
            if (k == 5'b10101) c.loads = 1; else c.loadc = 1;
            exp_q.push_back(c);
            if (k != 5'b10101) begin
                c = '0; c.writenum = i[7:5]; c.write = 1; exp_q.push_back(c);
            end
        end else if (k == 5'b01100 || k == 5'b10000) begin
            c = '0; c.readnum = i[10:8]; c.loada = 1; exp_q.push_back(c);
            c = '0; c.bsel = 1; c.loadc = 1; exp_q.push_back(c);
            c = '0; c.load_addr = 1; exp_q.push_back(c);
            if (k == 5'b01100) begin
                c = '0; c.mem_cmd = 2'b01; exp_q.push_back(c);
                c.vsel = 2'b11; c.writenum = i[7:5]; c.write = 1; exp_q.push_back(c);
            end else begin
                c = '0; c.readnum = i[7:5]; c.loadb = 1; exp_q.push_back(c);
                c = '0; c.asel = 1; c.loadc = 1; exp_q.push_back(c);
                c = '0; c.mem_cmd = 2'b10; exp_q.push_back(c);
            end
        end else begin
            for (int n = 0; n < 22; n++) begin
                c = '0; c.halted = 1; exp_q.push_back(c);
            end
        end
    endfunction

    // Pulse reset from a point just after a clock edge; RST must appear without waiting for clk
    task automatic apply_reset(input string name);
        reset_n = 1'b0;
        #1;
        tests++;
        if (act !== rst_v) begin fails++; $display("FAIL %s async got=%h exp=%h", name, act, rst_v); end
        @(posedge clk); #1;
        tests++;
        if (act !== rst_v) begin fails++; $display("FAIL %s held got=%h exp=%h", name, act, rst_v); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Run one instruction cycle by cycle; ir is garbage during IF1/IF2 to prove it is ignored there
    task automatic run_instr(input logic [15:0] i, input int limit, input string name);
        int n;
        n = exp_q.size();
        build(i);
        n = exp_q.size();
        for (int s = 0; s < n && (limit < 0 || s < limit); s++) begin
            ir = (s < 2) ? 16'($urandom) : i;
            #0;
            tests++;
            if (act !== exp_q[s]) begin
                fails++;
                $display("FAIL %s ir=%h cycle %0d got=%h exp=%h", name, i, s + 1, act, exp_q[s]);
            end
            @(posedge clk); #1;
        end
        if (limit < 0) begin
            if (exp_q[n-1].halted) apply_reset({name, "_halt_reset"});
            else begin
                tests++;
                if (act !== if1_v) begin fails++; $display("FAIL %s ir=%h next_if1 got=%h exp=%h", name, i, act, if1_v); end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
        run_instr(16'hD105, -1, "reset_fetch");
    endtask

    task automatic test_directed();
        run_instr(16'hD105, -1, "mov_imm");
        run_instr(16'hA04A, -1, "add");
        run_instr(16'hA901, -1, "cmp");
        run_instr(16'h6041, -1, "ldr");
        run_instr(16'h8041, -1, "str");
        run_instr(16'hC0B3, -1, "mov_reg");
        run_instr(16'hB8AA, -1, "mvn");
        run_instr(16'hB44D, -1, "and");
    endtask

    task automatic test_halt();
        run_instr(16'hE000, -1, "halt");
        run_instr(16'h3800, -1, "undef");
        run_instr(16'hA801, -1, "post_halt");
    endtask

    task automatic test_reset_mid_str();
        logic [15:0] i;
        for (int r = 0; r < 4; r++) begin
            i = {5'b10000, 11'($urandom)};
            run_instr(i, 4 + r + (r / 2) * 2, "str_abort");
            #2;
            reset_n = 1'b0;
            #1;
            tests++;
            if (act !== rst_v) begin fails++; $display("FAIL str_abort_async got=%h exp=%h", act, rst_v); end
            @(posedge clk); #1;
            tests++;
            if (act !== rst_v) begin fails++; $display("FAIL str_abort_held got=%h exp=%h", act, rst_v); end
            reset_n = 1'b1;
            @(posedge clk); #1;
            run_instr(i, -1, "str_restart");
        end
    endtask

    task automatic test_random();
        logic [4:0] ops [8];
        logic [15:0] i;
        ops = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10110, 5'b10101, 5'b01100, 5'b10000};
        for (int n = 0; n < 150; n++) begin
            i = 16'($urandom);
            if ($urandom_range(0, 7) != 0) i[15:11] = ops[$urandom_range(0, 7)];
            run_instr(i, -1, "random");
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_v = '0; rst_v.reset_pc = 1; rst_v.load_pc = 1;
        if1_v = '0; if1_v.addr_sel = 1; if1_v.mem_cmd = 2'b01;
        reset_n = 1'b1; ir = 16'h0000;
        #2;
        test_reset();
        test_directed();
        test_halt();
        test_reset_mid_str();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
